// File: rtl/shift_issue.sv
// Issue controller for the MIX shift group: decodes and indexes the address, hands the
// operands to an external shift unit, waits for it with a timeout, then writes back.
module shift_issue #(
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [30:0] instr,
  input  logic [29:0] ra_in,
  input  logic [29:0] rx_in,
  output logic [2:0]  ri_sel,
  input  logic [12:0] ri_val,
  output logic        sh_start,
  output logic [2:0]  sh_field,
  output logic [11:0] sh_m,
  output logic [29:0] sh_a,
  output logic [29:0] sh_x,
  input  logic        sh_done,
  input  logic [59:0] sh_out,
  output logic        wa_en,
  output logic [29:0] wa,
  output logic        wx_en,
  output logic [29:0] wx,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  // state  | meaning
  // IDLE   | waiting for go
  // IDX    | ri_val valid; decode checks and M = AA + rI
  // ISSUE  | sh_start pulse visible, operands held
  // WAIT   | waiting for sh_done, timeout down-counter running
  // WB     | writeback and done pulse visible
  typedef enum logic [2:0] {S_IDLE, S_IDX, S_ISSUE, S_WAIT, S_WB} state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t      r_state;
  logic [30:0] r_instr;
  logic [29:0] r_a;
  logic [29:0] r_x;
  logic [CW-1:0] r_cnt;
  logic [2:0]  r_ri_sel;
  logic        r_sh_start;
  logic [2:0]  r_sh_field;
  logic [11:0] r_sh_m;
  logic [29:0] r_sh_a;
  logic [29:0] r_sh_x;
  logic        r_wa_en;
  logic [29:0] r_wa;
  logic        r_wx_en;
  logic [29:0] r_wx;
  logic        r_done;
  logic        r_err;
  logic [1:0]  r_err_code;

  logic [5:0]  w_c;
  logic [5:0]  w_f;
  logic [5:0]  w_i;
  logic        w_aa_s;
  logic [11:0] w_aa_m;
  logic        w_ri_s;
  logic [11:0] w_ri_m;
  logic [12:0] w_sum;
  logic        w_ge;
  logic [11:0] w_m_mag;
  logic        w_m_neg;
  logic        w_ovf;
  logic        w_bad;

  always_comb begin
    w_c     = r_instr[5:0];
    w_f     = r_instr[11:6];
    w_i     = r_instr[17:12];
    w_aa_s  = r_instr[30];
    w_aa_m  = r_instr[29:18];
    w_ri_s  = (w_i == 6'd0) ? 1'b0 : ri_val[12];
    w_ri_m  = (w_i == 6'd0) ? 12'd0 : ri_val[11:0];
    w_sum   = {1'b0, w_aa_m} + {1'b0, w_ri_m};
    w_ge    = (w_aa_m >= w_ri_m);
    w_m_mag = 12'd0;
    w_m_neg = 1'b0;
    w_ovf   = 1'b0;
    if (w_aa_s == w_ri_s) begin
      w_m_mag = w_sum[11:0];
      w_ovf   = w_sum[12];
      w_m_neg = w_aa_s && (w_sum[11:0] != 12'd0);
    end else begin
      w_m_mag = w_ge ? (w_aa_m - w_ri_m) : (w_ri_m - w_aa_m);
      // a zero difference is +0, so only a nonzero result can be negative
      w_m_neg = (w_ge ? w_aa_s : w_ri_s) && (w_m_mag != 12'd0);
    end
    w_bad = (w_c != 6'd6) || (w_f > 6'd5) || (w_i >= 6'd7);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_instr    <= '0;
      r_a        <= '0;
      r_x        <= '0;
      r_cnt      <= '0;
      r_ri_sel   <= '0;
      r_sh_start <= 1'b0;
      r_sh_field <= '0;
      r_sh_m     <= '0;
      r_sh_a     <= '0;
      r_sh_x     <= '0;
      r_wa_en    <= 1'b0;
      r_wa       <= '0;
      r_wx_en    <= 1'b0;
      r_wx       <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_sh_start <= 1'b0;
      r_wa_en    <= 1'b0;
      r_wx_en    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= '0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_instr  <= instr;
            r_a      <= ra_in;
            r_x      <= rx_in;
            r_ri_sel <= instr[14:12];
            r_state  <= S_IDX;
          end
        end
        S_IDX: begin
          if (w_bad) begin
            r_err      <= 1'b1;
            r_err_code <= 2'd1;
            r_state    <= S_IDLE;
          end else if (w_ovf) begin
            r_err      <= 1'b1;
            r_err_code <= 2'd3;
            r_state    <= S_IDLE;
          end else if (w_m_neg) begin
            r_err      <= 1'b1;
            r_err_code <= 2'd2;
            r_state    <= S_IDLE;
          end else begin
            r_sh_start <= 1'b1;
            r_sh_field <= w_f[2:0];
            r_sh_m     <= w_m_mag;
            r_sh_a     <= r_a;
            r_sh_x     <= r_x;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= CW'(TIMEOUT - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (sh_done) begin
            r_wa_en <= 1'b1;
            r_wa    <= sh_out[59:30];
            // single-register shifts (F=0,1) leave rX untouched
            if (w_f >= 6'd2) begin
              r_wx_en <= 1'b1;
              r_wx    <= sh_out[29:0];
            end
            r_done  <= 1'b1;
            r_state <= S_WB;
          end else if (r_cnt == '0) begin
            r_err      <= 1'b1;
            r_err_code <= 2'd3;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WB: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ri_sel   = r_ri_sel;
  assign sh_start = r_sh_start;
  assign sh_field = r_sh_field;
  assign sh_m     = r_sh_m;
  assign sh_a     = r_sh_a;
  assign sh_x     = r_sh_x;
  assign wa_en    = r_wa_en;
  assign wa       = r_wa;
  assign wx_en    = r_wx_en;
  assign wx       = r_wx;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign err_code = r_err_code;

endmodule
